// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle for icache_refill_ctrl: CPU fetch port, memory read port and line data array port.
// The master modport is the controller's view; slave is the surrounding CPU/memory/array side.
interface icache_refill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SET_BITS   = 3
);
    localparam int unsigned LineW = LINE_WORDS * 32;

    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_flush;
    logic                  cpu_resp_valid;
    logic                  cpu_resp_ready;
    logic [31:0]           cpu_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [31:0]           mem_resp_data;

    logic [SET_BITS-1:0]   da_raddr;
    logic [LineW-1:0]      da_rdata;
    logic [SET_BITS-1:0]   da_waddr;
    logic                  da_wen;
    logic [LineW-1:0]      da_wdata;

    modport master (
        input  cpu_req_valid, cpu_addr, cpu_flush, cpu_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, da_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output mem_req_valid, mem_req_addr, mem_resp_ready,
        output da_raddr, da_waddr, da_wen, da_wdata
    );

    modport slave (
        output cpu_req_valid, cpu_addr, cpu_flush, cpu_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data, da_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_resp_ready,
        input  da_raddr, da_waddr, da_wen, da_wdata
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Read-only direct-mapped I-cache controller: tag/valid state, hit check, 8-beat line refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SET_BITS   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    icache_refill_ctrl_if.master      bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);
    localparam int unsigned OffBits  = $clog2(LINE_WORDS);
    localparam int unsigned LineBits = OffBits + 2;
    localparam int unsigned TagBits  = ADDR_WIDTH - SET_BITS - LineBits;
    localparam int unsigned Sets     = 1 << SET_BITS;

    typedef enum logic [2:0] {StWait, StCheck, StMemReq, StRecv, StRefill, StResp} state_e;

    state_e                            state_q, state_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [Sets-1:0]                   valid_q, valid_d;
    logic [TagBits-1:0]                tag_q [Sets];
    logic [TagBits-1:0]                tag_d [Sets];
    logic [OffBits-1:0]                cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][31:0]       buf_q, buf_d;
    logic [31:0]                       resp_data_q, resp_data_d;
    logic [LINE_WORDS-1:0][31:0]       rd_words;

    logic [TagBits-1:0]  addr_tag;
    logic [SET_BITS-1:0] idx;
    logic [OffBits-1:0]  off;
    logic                hit;
    logic                unused_byte_off;

    assign addr_tag        = addr_q[ADDR_WIDTH-1 -: TagBits];
    assign idx             = addr_q[LineBits +: SET_BITS];
    assign off             = addr_q[2 +: OffBits];
    assign hit             = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign rd_words        = bus.da_rdata;
    assign unused_byte_off = ^{bus.cpu_addr[1:0], addr_q[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:   if (!bus.cpu_flush && bus.cpu_req_valid) state_d = StCheck;
            StCheck:  state_d = hit ? StResp : StMemReq;
            StMemReq: if (bus.mem_req_ready) state_d = StRecv;
            StRecv: begin
                if (bus.mem_resp_valid && (cnt_q == OffBits'(LINE_WORDS - 1))) state_d = StRefill;
            end
            StRefill: state_d = StResp;
            StResp:   if (bus.cpu_resp_ready) state_d = StWait;
            default:  state_d = StWait;
        endcase
    end

    always_comb begin
        bus.cpu_req_ready  = (state_q == StWait) && !bus.cpu_flush;
        bus.cpu_resp_valid = (state_q == StResp);
        bus.cpu_resp_data  = resp_data_q;
        bus.mem_req_valid  = (state_q == StMemReq);
        bus.mem_req_addr   = {addr_q[ADDR_WIDTH-1:LineBits], {LineBits{1'b0}}};
        bus.mem_resp_ready = (state_q == StRecv);
        bus.da_raddr       = idx;
        bus.da_waddr       = idx;
        bus.da_wen         = (state_q == StRefill);
        bus.da_wdata       = buf_q;
    end

    // Datapath next-state; the line buffer is only ever read out in REFILL.
    always_comb begin
        addr_d      = addr_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            StWait: begin
                if (bus.cpu_flush) valid_d = '0;
                else if (bus.cpu_req_valid) addr_d = bus.cpu_addr;
            end
            StCheck:  if (hit) resp_data_d = rd_words[off];
            StMemReq: if (bus.mem_req_ready) cnt_d = '0;
            StRecv: begin
                if (bus.mem_resp_valid) begin
                    buf_d[cnt_q] = bus.mem_resp_data;
                    cnt_d        = cnt_q + 1'b1;
                end
            end
            StRefill: begin
                valid_d[idx] = 1'b1;
                tag_d[idx]   = addr_tag;
                resp_data_d  = buf_q[off];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            valid_q     <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            resp_data_q <= '0;
            for (int i = 0; i < Sets; i++) tag_q[i] <= '0;
        end else begin
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            resp_data_q <= resp_data_d;
            tag_q       <= tag_d;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StCheck) begin
            if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: drives CPU and memory ports, models the line data array.
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_refill_ctrl_if bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_refill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // Line data array beside the controller: combinational read, synchronous write.
    logic [255:0] da_mem [8];
    always @(posedge clk) if (bus.da_wen) da_mem[bus.da_waddr] <= bus.da_wdata;
    assign bus.da_rdata = da_mem[bus.da_raddr];

    int beats_seen = 0;
    int wen_seen   = 0;
    int req_seen   = 0;
    always @(posedge clk) begin
        if (bus.mem_resp_valid && bus.mem_resp_ready) beats_seen <= beats_seen + 1;
        if (bus.da_wen) wen_seen <= wen_seen + 1;
        if (bus.mem_req_valid && bus.mem_req_ready) req_seen <= req_seen + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_accept(input logic [31:0] addr);
        bus.cpu_addr      = addr;
        bus.cpu_req_valid = 1'b1;
        #1;
        chk("req_ready_wait", bus.cpu_req_ready, 1);
        tick();
        bus.cpu_req_valid = 1'b0;
    endtask

    task automatic respond();
        bus.cpu_resp_ready = 1'b1;
        tick();
        bus.cpu_resp_ready = 1'b0;
        #1;
        chk("resp_valid_after_hs", bus.cpu_resp_valid, 0);
        chk("req_ready_after_hs", bus.cpu_req_ready, 1);
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_word);
        int r0, w0;
        r0 = req_seen;
        w0 = wen_seen;
        fetch_accept(addr);
        chk("hit_check_no_resp", bus.cpu_resp_valid, 0);
        tick();
        chk("hit_resp_valid", bus.cpu_resp_valid, 1);
        chk("hit_resp_data", bus.cpu_resp_data, exp_word);
        chk("hit_no_memreq", bus.mem_req_valid, 0);
        respond();
        chk("hit_req_count", req_seen - r0, 0);
        chk("hit_wen_count", wen_seen - w0, 0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_line_addr,
                           input logic [31:0] base, input logic [2:0] exp_idx,
                           input logic [31:0] exp_word, input int gap, input int hold);
        int b0, w0;
        logic [255:0] line;
        b0 = beats_seen;
        w0 = wen_seen;
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = base + i;
        fetch_accept(addr);
        tick();
        chk("miss_memreq_valid", bus.mem_req_valid, 1);
        chk("miss_memreq_addr", bus.mem_req_addr, exp_line_addr);
        tick();
        chk("memreq_held_valid", bus.mem_req_valid, 1);
        chk("memreq_held_addr", bus.mem_req_addr, exp_line_addr);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        chk("recv_ready", bus.mem_resp_ready, 1);
        chk("recv_memreq_drop", bus.mem_req_valid, 0);
        for (int i = 0; i < 8; i++) begin
            if (gap != 0) begin
                bus.mem_resp_valid = 1'b0;
                tick();
                chk("stall_ready", bus.mem_resp_ready, 1);
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + i;
            tick();
        end
        // With gaps, keep offering a ninth beat through REFILL; it must not be taken.
        bus.mem_resp_valid = (gap != 0);
        #1;
        chk("refill_wen", bus.da_wen, 1);
        chk("refill_waddr", bus.da_waddr, exp_idx);
        chk("refill_wdata", bus.da_wdata, line);
        chk("refill_no_recv", bus.mem_resp_ready, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("miss_resp_valid", bus.cpu_resp_valid, 1);
        chk("miss_resp_data", bus.cpu_resp_data, exp_word);
        chk("miss_wen_drop", bus.da_wen, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("bp_resp_valid", bus.cpu_resp_valid, 1);
            chk("bp_resp_data", bus.cpu_resp_data, exp_word);
            chk("bp_req_ready", bus.cpu_req_ready, 0);
        end
        chk("miss_beat_count", beats_seen - b0, 8);
        respond();
        chk("miss_wen_count", wen_seen - w0, 1);
    endtask

    initial begin
        rst                = 1'b1;
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_flush      = 1'b0;
        bus.cpu_resp_ready = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick();
        tick();
        chk("rst_resp_valid", bus.cpu_resp_valid, 0);
        chk("rst_memreq_valid", bus.mem_req_valid, 0);
        chk("rst_memresp_ready", bus.mem_resp_ready, 0);
        chk("rst_wen", bus.da_wen, 0);
        chk("rst_resp_data", bus.cpu_resp_data, 0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", bus.cpu_req_ready, 1);

        // Cold miss, hit in same line, conflict miss, refetch with back-pressure and gaps.
        do_miss(32'h0000_0104, 32'h0000_0100, 32'hA0, 3'd0, 32'hA1, 0, 0);
        do_hit(32'h0000_011C, 32'hA7);
        do_miss(32'h0000_1100, 32'h0000_1100, 32'hB0, 3'd0, 32'hB0, 0, 0);
        do_miss(32'h0000_0100, 32'h0000_0100, 32'hC0, 3'd0, 32'hC0, 1, 5);
        do_hit(32'h0000_0104, 32'hC1);

        // Flush together with a request: request dropped, line invalidated.
        bus.cpu_flush     = 1'b1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = 32'h0000_0104;
        #1;
        chk("flush_req_ready", bus.cpu_req_ready, 0);
        tick();
        bus.cpu_flush     = 1'b0;
        bus.cpu_req_valid = 1'b0;
        #1;
        chk("flush_stay_wait", bus.cpu_req_ready, 1);
        tick();
        chk("flush_no_memreq", bus.mem_req_valid, 0);
        chk("flush_no_resp", bus.cpu_resp_valid, 0);
        do_miss(32'h0000_0104, 32'h0000_0100, 32'hD0, 3'd0, 32'hD1, 0, 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", hit_cnt, 2);
        chk("perf_miss", miss_cnt, 4);
`endif

        // Reset in RECV after 3 beats.
        fetch_accept(32'h0000_2048);
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h90 + i;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", bus.cpu_resp_valid, 0);
        chk("mid_rst_memreq_valid", bus.mem_req_valid, 0);
        chk("mid_rst_memresp_ready", bus.mem_resp_ready, 0);
        chk("mid_rst_wen", bus.da_wen, 0);
        chk("mid_rst_resp_data", bus.cpu_resp_data, 0);
        chk("mid_rst_req_ready", bus.cpu_req_ready, 1);
`ifdef ICACHE_PERF_CNT_EN
        chk("mid_rst_perf_hit", hit_cnt, 0);
        chk("mid_rst_perf_miss", miss_cnt, 0);
`endif
        tick();
        rst                = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();
        do_miss(32'h0000_0104, 32'h0000_0100, 32'hF0, 3'd0, 32'hF1, 0, 0);
        do_miss(32'h0000_2048, 32'h0000_2040, 32'hE0, 3'd2, 32'hE2, 0, 0);
        do_hit(32'h0000_2040, 32'hE0);
`ifdef ICACHE_PERF_CNT_EN
        chk("post_rst_perf_hit", hit_cnt, 1);
        chk("post_rst_perf_miss", miss_cnt, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
